control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port MEM_DATA, input, 32, instruction word from memory, sampled in FETCH.
REQ-004 SHALL have port ZERO, input, 1, ALU zero flag, sampled at the EXE->MEM edge.
REQ-005 SHALL have port STATE, output, 3, current state: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4.
REQ-006 SHALL have port ALU_OPRN, output, 6, ALU operation code: 0x01 add, 0x02 sub, 0x03 mul, 0x04 srl, 0x05 sll, 0x06 and, 0x07 or, 0x08 nor, 0x09 slt, 0x00 none.
REQ-007 SHALL have port OP2_SEL, output, 2, ALU operand-2 source: 0 rt register, 1 sign-extended imm, 2 zero-extended imm, 3 shamt.
REQ-008 SHALL have ports RF_READ and RF_WRITE, output, 1 each, register-file strobes; RF_WADDR, output, 5, write index.
REQ-009 SHALL have ports MEM_READ, MEM_WRITE and MEM_ADDR_SEL, output, 1 each, memory strobes; address from PC (0) or ALU result (1).
REQ-010 SHALL have ports PC_LOAD, output, 1; PC_SEL, output, 2 (0 PC+1, 1 PC+1+simm, 2 jump target IR[25:0]); WB_SEL, output, 1 (0 ALU, 1 memory).

Function
REQ-011 SHALL sequence FETCH->DECODE->EXE->MEM->WB->FETCH unconditionally, one state per cycle; every instruction takes exactly 5 cycles.
REQ-012 SHALL load the instruction register (IR) from MEM_DATA on the FETCH->DECODE edge only.
REQ-013 SHALL decode outputs from STATE and IR only, valid for the whole cycle of that state.
REQ-014 SHALL, in FETCH: MEM_READ=1, MEM_ADDR_SEL=0; all other strobes 0.
REQ-015 SHALL, in DECODE: RF_READ=1; all other strobes 0.
REQ-016 SHALL, in EXE: drive ALU_OPRN/OP2_SEL per the IR decode; all strobes 0.
REQ-017 SHALL decode R-type (opcode 0x00) funct as: 0x20 add, 0x22 sub, 0x2c mul, 0x02 srl (OP2_SEL=3), 0x01 sll (OP2_SEL=3), 0x24 and, 0x25 or, 0x27 nor, 0x2a slt; otherwise OP2_SEL=0; RF_WADDR=IR[15:11].
REQ-018 SHALL decode I-type: 0x08 addi add/sign; 0x1d muli mul/sign; 0x0c andi and/zero; 0x0d ori or/zero; 0x0a slti slt/sign; 0x23 lw add/sign; 0x2b sw add/sign; 0x04 beq and 0x05 bne sub/OP2_SEL=0; RF_WADDR=IR[20:16].
REQ-019 SHALL decode 0x02 jmp with ALU_OPRN=0x00.
REQ-020 SHALL register ZERO into a branch flag on the EXE->MEM edge; ZERO in other states is ignored.
REQ-021 SHALL, in MEM: lw MEM_READ=1, MEM_ADDR_SEL=1; sw MEM_WRITE=1, MEM_ADDR_SEL=1; all other instructions drive no strobes; ALU_OPRN/OP2_SEL held as in EXE.
REQ-022 SHALL, in WB: PC_LOAD=1 for every instruction.
REQ-023 SHALL, in WB, write back as follows: RF_WRITE=1 for R-type and I-type ALU ops and lw (WB_SEL=1 for lw, else 0); RF_WRITE=0 for sw, beq, bne, jmp and unknown.
REQ-024 SHALL, in WB, select PC_SEL=1 for beq with flag=1 or bne with flag=0, PC_SEL=2 for jmp, else 0.
REQ-025 SHALL treat any undefined opcode or funct as NOP: ALU_OPRN=0x00, no RF/MEM writes, PC_SEL=0, still 5 cycles.
REQ-026 SHALL never assert MEM_READ and MEM_WRITE, or RF_WRITE and MEM_WRITE, together.

Reset
REQ-027 SHALL, while RST=0, force STATE=WB, IR=0x00000000 and branch flag=0; all outputs evaluate to 0 (NOP in WB, PC_LOAD forced 0 during reset).
REQ-028 SHALL, on the first rising CLK after RST deasserts, enter FETCH; RST falling mid-instruction aborts it with no further strobes.

Verification
REQ-029 Reset then release -> STATE 4,0,1,2,3,4,0; MEM_READ=1 in cycle 1 only; no RF_WRITE/MEM_WRITE in the first instruction fetch.
REQ-030 MEM_DATA=0x00221820 (add r3,r1,r2) -> EXE ALU_OPRN=0x01, OP2_SEL=0; WB RF_WRITE=1, RF_WADDR=3, WB_SEL=0, PC_SEL=0.
REQ-031 lw 0x8C250004 -> EXE ALU_OPRN=0x01, OP2_SEL=1; MEM MEM_READ=1, MEM_ADDR_SEL=1; WB RF_WRITE=1, RF_WADDR=5, WB_SEL=1.
REQ-032 beq 0x10220003 with ZERO=1 at end of EXE -> WB PC_SEL=1, RF_WRITE=0; same with ZERO=0 -> PC_SEL=0; ZERO toggled in MEM -> no effect.
REQ-033 Opcode 0x3F -> ALU_OPRN=0x00 throughout, no writes, PC_SEL=0, PC_LOAD=1 in WB.
REQ-034 RST low during MEM of sw -> MEM_WRITE drops immediately, STATE=4, outputs 0; after release, the next instruction starts in FETCH.

Source files
------------

// File: rtl/control_unit_if.sv
// Bus between the multi-cycle control unit and the datapath/memory.
// The control unit sits on the slave side and the datapath on the master side.
interface control_unit_if;
  logic [31:0] MEM_DATA;
  logic        ZERO;
  logic [2:0]  STATE;
  logic [5:0]  ALU_OPRN;
  logic [1:0]  OP2_SEL;
  logic        RF_READ;
  logic        RF_WRITE;
  logic [4:0]  RF_WADDR;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic        MEM_ADDR_SEL;
  logic        PC_LOAD;
  logic [1:0]  PC_SEL;
  logic        WB_SEL;

  modport slave (
    input  MEM_DATA, ZERO,
    output STATE, ALU_OPRN, OP2_SEL, RF_READ, RF_WRITE, RF_WADDR,
           MEM_READ, MEM_WRITE, MEM_ADDR_SEL, PC_LOAD, PC_SEL, WB_SEL
  );

  modport master (
    output MEM_DATA, ZERO,
    input  STATE, ALU_OPRN, OP2_SEL, RF_READ, RF_WRITE, RF_WADDR,
           MEM_READ, MEM_WRITE, MEM_ADDR_SEL, PC_LOAD, PC_SEL, WB_SEL
  );
endinterface

// File: rtl/control_unit.sv
// Five-state multi-cycle control unit: FETCH, DECODE, EXE, MEM, WB.
// Outputs are decoded from the current state and the instruction register.
module control_unit (
  input logic              CLK,
  input logic              RST,
  control_unit_if.slave    bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [31:0] ir;
  logic        flag;

  logic [5:0]  opcode, funct;
  logic [5:0]  dec_alu;
  logic [1:0]  dec_op2;
  logic [4:0]  dec_waddr;
  logic        dec_wr, dec_lw, dec_sw, dec_beq, dec_bne, dec_jmp;
  logic        unused_ir;

  assign opcode    = ir[31:26];
  assign funct     = ir[5:0];
  // rs, shamt and jump target are consumed by the datapath, not by control
  assign unused_ir = ^{ir[25:21], ir[10:6]};

  // State register; reset parks in WB so the first clock afterwards enters FETCH
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= WB;
    else      state <= state_next;
  end

  // Instruction register, captured only while fetching
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                ir <= '0;
    else if (state == FETCH) ir <= bus.MEM_DATA;
  end

  // Branch flag, captured from the ALU zero output at the end of EXE
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)              flag <= 1'b0;
    else if (state == EXE) flag <= bus.ZERO;
  end

  // Unconditional five-step sequence
  always_comb begin
    state_next = FETCH;
    unique case (state)
      FETCH:   state_next = DECODE;
      DECODE:  state_next = EXE;
      EXE:     state_next = MEM;
      MEM:     state_next = WB;
      WB:      state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Instruction decode; anything unrecognised falls through as a NOP
  always_comb begin
    dec_alu   = '0;
    dec_op2   = '0;
    dec_waddr = '0;
    dec_wr    = 1'b0;
    dec_lw    = 1'b0;
    dec_sw    = 1'b0;
    dec_beq   = 1'b0;
    dec_bne   = 1'b0;
    dec_jmp   = 1'b0;
    case (opcode)
      6'h00: begin
        dec_waddr = ir[15:11];
        dec_wr    = 1'b1;
        case (funct)
          6'h20:   dec_alu = 6'h01;
          6'h22:   dec_alu = 6'h02;
          6'h2c:   dec_alu = 6'h03;
          6'h02:   begin dec_alu = 6'h04; dec_op2 = 2'd3; end
          6'h01:   begin dec_alu = 6'h05; dec_op2 = 2'd3; end
          6'h24:   dec_alu = 6'h06;
          6'h25:   dec_alu = 6'h07;
          6'h27:   dec_alu = 6'h08;
          6'h2a:   dec_alu = 6'h09;
          default: begin dec_wr = 1'b0; dec_waddr = '0; end
        endcase
      end
      6'h08:   begin dec_alu = 6'h01; dec_op2 = 2'd1; dec_wr = 1'b1; dec_waddr = ir[20:16]; end
      6'h1d:   begin dec_alu = 6'h03; dec_op2 = 2'd1; dec_wr = 1'b1; dec_waddr = ir[20:16]; end
      6'h0c:   begin dec_alu = 6'h06; dec_op2 = 2'd2; dec_wr = 1'b1; dec_waddr = ir[20:16]; end
      6'h0d:   begin dec_alu = 6'h07; dec_op2 = 2'd2; dec_wr = 1'b1; dec_waddr = ir[20:16]; end
      6'h0a:   begin dec_alu = 6'h09; dec_op2 = 2'd1; dec_wr = 1'b1; dec_waddr = ir[20:16]; end
      6'h23:   begin dec_alu = 6'h01; dec_op2 = 2'd1; dec_wr = 1'b1; dec_waddr = ir[20:16]; dec_lw = 1'b1; end
      6'h2b:   begin dec_alu = 6'h01; dec_op2 = 2'd1; dec_sw = 1'b1; end
      6'h04:   begin dec_alu = 6'h02; dec_beq = 1'b1; end
      6'h05:   begin dec_alu = 6'h02; dec_bne = 1'b1; end
      6'h02:   dec_jmp = 1'b1;
      default: ;
    endcase
  end

  assign bus.STATE = state;

  // Per-state strobes; PC_LOAD is gated by reset so the parked WB state stays silent
  always_comb begin
    bus.ALU_OPRN     = '0;
    bus.OP2_SEL      = '0;
    bus.RF_READ      = 1'b0;
    bus.RF_WRITE     = 1'b0;
    bus.RF_WADDR     = '0;
    bus.MEM_READ     = 1'b0;
    bus.MEM_WRITE    = 1'b0;
    bus.MEM_ADDR_SEL = 1'b0;
    bus.PC_LOAD      = 1'b0;
    bus.PC_SEL       = '0;
    bus.WB_SEL       = 1'b0;
    unique case (state)
      FETCH:  bus.MEM_READ = 1'b1;
      DECODE: bus.RF_READ  = 1'b1;
      EXE: begin
        bus.ALU_OPRN = dec_alu;
        bus.OP2_SEL  = dec_op2;
      end
      MEM: begin
        bus.ALU_OPRN     = dec_alu;
        bus.OP2_SEL      = dec_op2;
        bus.MEM_READ     = dec_lw;
        bus.MEM_WRITE    = dec_sw;
        bus.MEM_ADDR_SEL = dec_lw | dec_sw;
      end
      WB: begin
        bus.PC_LOAD  = RST;
        bus.RF_WRITE = dec_wr;
        bus.RF_WADDR = dec_waddr;
        bus.WB_SEL   = dec_lw;
        if (dec_jmp)                                   bus.PC_SEL = 2'd2;
        else if ((dec_beq && flag) || (dec_bne && !flag)) bus.PC_SEL = 2'd1;
      end
      default: ;
    endcase
  end

endmodule
